// File: rtl/seg7_pkg.sv
// Shared glyph constants and the nibble-to-segment lookup for the 7-segment scan driver.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data/pin bundle between the core (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    // No backpressure: inputs are sampled only at frame boundaries and
    // frame_start is a one-cycle strobe marking the cycle the shadows took them.
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              brightness;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    modport master (
        output value, dp_in, digit_en, brightness,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  value, dp_in, digit_en, brightness,
        output seg, dp, an, frame_start
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} glyph.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame-coherent shadows, ghost guard and PWM.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_W      = 18,
    parameter int ACTIVE_LOW = 1
) (
    input logic clk,
    input logic clr,
    seg7_scan_driver_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_IDLE = {7{INV}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{INV}};

    logic [DIV_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [4*NUM_DIGITS-1:0] value_sh_q, value_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
    logic [3:0]              bright_sh_q, bright_sh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    frame_edge;
    logic [NUM_DIGITS-1:0]   en_eff;
    logic [NUM_DIGITS-1:0]   an_hot;
    logic [3:0]              nibble_sel;
    logic                    en_sel;
    logic                    dp_sel;
    logic [3:0]              phase;
    logic                    lit;
    logic [6:0]              glyph;

    always_comb begin
        frame_edge    = (&prescaler_q) && (index_q == LAST_IDX);
        prescaler_d   = prescaler_q + 1'b1;
        index_d       = index_q;
        if (&prescaler_q) begin
            index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
        end
        value_sh_d    = value_sh_q;
        dp_sh_d       = dp_sh_q;
        en_sh_d       = en_sh_q;
        bright_sh_d   = bright_sh_q;
        if (frame_edge) begin
            value_sh_d  = bus.value;
            dp_sh_d     = bus.dp_in;
            en_sh_d     = bus.digit_en;
            bright_sh_d = bus.brightness;
        end
        frame_start_d = frame_edge;
    end

    // Effective enables come from shadows only, so blanking never tears a frame.
`ifdef SEG7_LZ_BLANK_EN
    logic hi_zero;
    always_comb begin
        en_eff  = en_sh_q;
        hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            hi_zero = hi_zero && (value_sh_q[4*k +: 4] == 4'h0);
            if (hi_zero && !dp_sh_q[k]) begin
                en_eff[k] = 1'b0;
            end
        end
    end
`else
    always_comb begin
        en_eff = en_sh_q;
    end
`endif

    always_comb begin
        nibble_sel = 4'h0;
        en_sel     = 1'b0;
        dp_sel     = 1'b0;
        an_hot     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_q == IDX_W'(k)) begin
                nibble_sel = value_sh_q[4*k +: 4];
                en_sel     = en_eff[k];
                dp_sel     = dp_sh_q[k];
                an_hot[k]  = 1'b1;
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (nibble_sel),
        .glyph  (glyph)
    );

    // Phase 0 stays dark so the segment bus settles before the next anode turns on.
    always_comb begin
        phase = prescaler_q[DIV_W-1 -: 4];
        lit   = en_sel && (phase != 4'h0) && (phase <= bright_sh_q);
        seg_d = (lit ? glyph : SEG_OFF) ^ SEG_IDLE;
        dp_d  = (lit & dp_sel) ^ INV;
        an_d  = (lit ? an_hot : '0) ^ AN_IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            value_sh_q    <= '0;
            dp_sh_q       <= '0;
            en_sh_q       <= '0;
            bright_sh_q   <= '0;
            seg_q         <= SEG_IDLE;
            dp_q          <= INV;
            an_q          <= AN_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            value_sh_q    <= value_sh_d;
            dp_sh_q       <= dp_sh_d;
            en_sh_q       <= en_sh_d;
            bright_sh_q   <= bright_sh_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 16-cycle slots, active-low pins).
// Expectations follow SEG7_LZ_BLANK_EN when it is defined for the build.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .DIV_W      (DW),
        .ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Slot record: {lit-cycle mask[15:0], an[3:0], seg[6:0], dp, flags[1:0]}
    logic [29:0] exp_q[$];

    function automatic logic [29:0] slot_rec(input int dig, input logic lit,
                                             input logic [6:0] seg_al,
                                             input logic dp_on, input int br);
        int m;
        logic [15:0] mask;
        logic [3:0] an_al;
        if (!lit || br == 0) return {16'h0000, 4'hF, 7'h7F, 1'b1, 2'b00};
        m     = (1 << (br + 1)) - 1;
        mask  = m[15:0] & 16'hFFFE;
        an_al = ~(4'b0001 << dig);
        return {mask, an_al, seg_al, ~dp_on, 2'b00};
    endfunction

    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.frame_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL fs_timeout: frame_start not seen within 200 cycles (required a pulse every 64)");
        end
    endtask

    // Drives one input set and pushes the 4 slots expected in the frame that latches it.
    task automatic apply(input bit sync, input int delay, input logic [15:0] v,
                         input logic [3:0] dpi, input logic [3:0] en,
                         input logic [3:0] br, input logic [27:0] exp_seg,
                         input logic [3:0] exp_lit, input logic [3:0] exp_dp);
        if (sync) wait_fs();
        repeat (delay) @(negedge clk);
        bus.value      = v;
        bus.dp_in      = dpi;
        bus.digit_en   = en;
        bus.brightness = br;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(slot_rec(k, exp_lit[k], exp_seg[7*k +: 7], exp_dp[k], int'(br)));
        end
    endtask

    // Monitor
    bit          armed = 1'b0;
    bit          predark = 1'b0;
    bit          in_frame = 1'b0;
    bit          fs_valid = 1'b0;
    int          pre_bad = 0;
    int          since_fs = 0;
    int          pos = 0;
    logic [15:0] m_mask [4];
    logic [3:0]  m_an   [4];
    logic [6:0]  m_seg  [4];
    logic        m_dp   [4];
    logic [1:0]  m_flg  [4];
    bit          m_got  [4];

    initial begin
        logic [29:0] act;
        logic [29:0] exp;
        int s;
        int cy;
        forever begin
            @(posedge clk);
            #1;
            if (clr) begin
                checks++;
                if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_out: an=%b seg=%h dp=%b fs=%b, required an=1111 seg=7f dp=1 fs=0",
                             bus.an, bus.seg, bus.dp, bus.frame_start);
                end
                if (in_frame) begin
                    for (int k = 0; k < 4; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                in_frame = 1'b0;
                armed    = 1'b1;
                predark  = 1'b1;
                pre_bad  = 0;
                fs_valid = 1'b0;
            end else if (armed) begin
                since_fs++;
                if (in_frame) begin
                    s  = pos / 16;
                    cy = pos % 16;
                    if (bus.an !== 4'hF) begin
                        m_mask[s][cy] = 1'b1;
                        if (!m_got[s]) begin
                            m_got[s] = 1'b1;
                            m_an[s]  = bus.an;
                            m_seg[s] = bus.seg;
                            m_dp[s]  = bus.dp;
                        end else if (m_an[s] !== bus.an || m_seg[s] !== bus.seg || m_dp[s] !== bus.dp) begin
                            m_flg[s][1] = 1'b1;
                        end
                    end else if (bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
                        m_flg[s][0] = 1'b1;
                    end
                    pos++;
                    if (pos == 64) begin
                        in_frame = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            checks++;
                            act = {m_mask[k], m_an[k], m_seg[k], m_dp[k], m_flg[k]};
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL slot%0d_unexpected: got %h with no expectation queued", k, act);
                            end else begin
                                exp = exp_q.pop_front();
                                if (act !== exp) begin
                                    errors++;
                                    $display("FAIL slot%0d: got mask=%h an=%b seg=%h dp=%b flags=%b, required mask=%h an=%b seg=%h dp=%b flags=%b",
                                             k, act[29:14], act[13:10], act[9:3], act[2], act[1:0],
                                             exp[29:14], exp[13:10], exp[9:3], exp[2], exp[1:0]);
                                end
                            end
                        end
                    end
                end
                if (predark && bus.frame_start !== 1'b1 && bus.an !== 4'hF) pre_bad++;
                if (bus.frame_start === 1'b1) begin
                    if (predark) begin
                        checks++;
                        if (pre_bad != 0) begin
                            errors++;
                            $display("FAIL predark: %0d lit cycles before first frame_start, required 0", pre_bad);
                        end
                        predark = 1'b0;
                    end
                    if (fs_valid) begin
                        checks++;
                        if (since_fs != 64) begin
                            errors++;
                            $display("FAIL fs_period: %0d cycles between frame_start pulses, required 64", since_fs);
                        end
                    end
                    fs_valid = 1'b1;
                    since_fs = 0;
                    in_frame = 1'b1;
                    pos      = 0;
                    for (int k = 0; k < 4; k++) begin
                        m_mask[k] = 16'h0000;
                        m_an[k]   = 4'hF;
                        m_seg[k]  = 7'h7F;
                        m_dp[k]   = 1'b1;
                        m_flg[k]  = 2'b00;
                        m_got[k]  = 1'b0;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        bus.value      = '0;
        bus.dp_in      = '0;
        bus.digit_en   = '0;
        bus.brightness = '0;
        clr            = 1'b1;
        apply(1'b0, 0, 16'h1234, 4'h0, 4'hF, 4'd15,
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b0000);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        apply(1'b1, 0, 16'h1234, 4'h0, 4'hF, 4'd15,
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b0000);
        apply(1'b1, 40, 16'hABCD, 4'h0, 4'hF, 4'd15,
              {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111, 4'b0000);
        apply(1'b1, 0, 16'hABCD, 4'h0, 4'hF, 4'd4,
              {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111, 4'b0000);
        apply(1'b1, 0, 16'hABCD, 4'h0, 4'hF, 4'd0,
              {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0000, 4'b0000);
        apply(1'b1, 0, 16'hABCD, 4'b0001, 4'b0101, 4'd15,
              {7'h7F, 7'h03, 7'h7F, 7'h21}, 4'b0101, 4'b0001);
`ifdef SEG7_LZ_BLANK_EN
        apply(1'b1, 0, 16'h0070, 4'h0, 4'hF, 4'd15,
              {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0011, 4'b0000);
        apply(1'b1, 0, 16'h0000, 4'h0, 4'hF, 4'd15,
              {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0001, 4'b0000);
        apply(1'b1, 0, 16'h0000, 4'b0100, 4'hF, 4'd15,
              {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0101, 4'b0100);
`else
        apply(1'b1, 0, 16'h0070, 4'h0, 4'hF, 4'd15,
              {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111, 4'b0000);
        apply(1'b1, 0, 16'h0000, 4'h0, 4'hF, 4'd15,
              {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0000);
        apply(1'b1, 0, 16'h0000, 4'b0100, 4'hF, 4'd15,
              {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b0100);
`endif
        apply(1'b1, 0, 16'h1234, 4'h0, 4'hF, 4'd15,
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b0000);

        // One-cycle reset while digit 2 is at phase 7 of the frame showing 1234.
        wait_fs();
        repeat (39) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        apply(1'b0, 0, 16'h1234, 4'h0, 4'hF, 4'd15,
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b0000);
        apply(1'b1, 0, 16'h5678, 4'b1010, 4'hF, 4'd15,
              {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, 4'b1010);

        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d slot expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
